// File: rtl/cc_bus_decoder_load.sv
// cc_bus_decoder_load
// Decodes a bus destination address into a one-hot register load strobe.
// A request (address + data) is taken with a valid/ready handshake in IDLE.
// A legal address produces a one-cycle STROBE with done. An address
// >= NUM_REGS produces a one-cycle ERROR pulse instead.
// Address 0 is the hardwired zero register: done pulses but no load bit is set.
// Optional feature: define CC_BUSDEC_WRITE_COUNT_EN to add CC_BUSDEC_count_OutBUS,
// a saturating 8-bit count of STROBE cycles.
module cc_bus_decoder_load #(
  parameter int DATAWIDTH_BUS  = 4,
  parameter int DATAWIDTH_DATA = 8,
  parameter int NUM_REGS       = 12
) (
  input  logic                      CC_BUSDEC_CLOCK_50,
  input  logic                      CC_BUSDEC_RESET_InLow,
  input  logic                      CC_BUSDEC_valid_In,
  input  logic [DATAWIDTH_BUS-1:0]  CC_BUSDEC_address_InBUS,
  input  logic [DATAWIDTH_DATA-1:0] CC_BUSDEC_data_InBUS,
  output logic                      CC_BUSDEC_ready_Out,
  output logic [NUM_REGS-1:0]       CC_BUSDEC_load_OutBUS,
  output logic [DATAWIDTH_DATA-1:0] CC_BUSDEC_data_OutBUS,
  output logic                      CC_BUSDEC_done_Out,
  output logic                      CC_BUSDEC_error_Out
`ifdef CC_BUSDEC_WRITE_COUNT_EN
  ,
  output logic [7:0]                CC_BUSDEC_count_OutBUS
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    ERROR  = 2'd2
  } state_e;

  // The address is widened by one bit so the bound check is unsigned and
  // still correct when NUM_REGS equals 2**DATAWIDTH_BUS.
  localparam logic [DATAWIDTH_BUS:0] NUM_REGS_W = (DATAWIDTH_BUS+1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0]    LOAD_ONE   = NUM_REGS'(1);

  state_e                    state_q, state_d;
  logic [DATAWIDTH_BUS-1:0]  addr_q,  addr_d;
  logic [DATAWIDTH_DATA-1:0] data_q,  data_d;
  logic                      addr_legal;

  assign addr_legal = ({1'b0, CC_BUSDEC_address_InBUS} < NUM_REGS_W);

  // Next-state logic: capture in IDLE, then spend exactly one cycle in STROBE or ERROR.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (CC_BUSDEC_valid_In) begin
          addr_d = CC_BUSDEC_address_InBUS;
          if (addr_legal) begin
            // Output data follows only legal writes; a rejected write leaves it alone.
            data_d  = CC_BUSDEC_data_InBUS;
            state_d = STROBE;
          end else begin
            state_d = ERROR;
          end
        end
      end
      STROBE:  state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured request registers.
  always_ff @(posedge CC_BUSDEC_CLOCK_50 or negedge CC_BUSDEC_RESET_InLow) begin
    // NOTE: the async reset clears every flop here so all outputs drop immediately on reset.
    if (!CC_BUSDEC_RESET_InLow) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  always_comb begin
    CC_BUSDEC_ready_Out   = (state_q == IDLE);
    CC_BUSDEC_done_Out    = (state_q == STROBE);
    CC_BUSDEC_error_Out   = (state_q == ERROR);
    CC_BUSDEC_data_OutBUS = data_q;
    CC_BUSDEC_load_OutBUS = '0;
    if ((state_q == STROBE) && (addr_q != '0)) begin
      CC_BUSDEC_load_OutBUS = LOAD_ONE << addr_q;
    end
  end

`ifdef CC_BUSDEC_WRITE_COUNT_EN
  logic [7:0] count_q, count_d;

  // Count STROBE cycles, including zero-register writes, and saturate at 255.
  always_comb begin
    count_d = count_q;
    if ((state_q == STROBE) && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Write counter register.
  always_ff @(posedge CC_BUSDEC_CLOCK_50 or negedge CC_BUSDEC_RESET_InLow) begin
    if (!CC_BUSDEC_RESET_InLow) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign CC_BUSDEC_count_OutBUS = count_q;
`else
  // No write counter in this build.
`endif

endmodule

// File: tb/tb_cc_bus_decoder_load.sv
// tb_cc_bus_decoder_load
// Drives requests into cc_bus_decoder_load and pushes the reference model's
// expected response into a scoreboard queue. A monitor pops and compares
// whenever done or error is presented.
// Define CC_BUSDEC_WRITE_COUNT_EN to also exercise the write counter.
module tb_cc_bus_decoder_load;

  localparam int NR = 12;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [3:0]  addr;
  logic [7:0]  data;
  logic        ready;
  logic [11:0] load;
  logic [7:0]  data_out;
  logic        done;
  logic        error;
`ifdef CC_BUSDEC_WRITE_COUNT_EN
  logic [7:0]  count;
`endif

  cc_bus_decoder_load dut (
    .CC_BUSDEC_CLOCK_50      (clk),
    .CC_BUSDEC_RESET_InLow   (rst_n),
    .CC_BUSDEC_valid_In      (valid),
    .CC_BUSDEC_address_InBUS (addr),
    .CC_BUSDEC_data_InBUS    (data),
    .CC_BUSDEC_ready_Out     (ready),
    .CC_BUSDEC_load_OutBUS   (load),
    .CC_BUSDEC_data_OutBUS   (data_out),
    .CC_BUSDEC_done_Out      (done),
    .CC_BUSDEC_error_Out     (error)
`ifdef CC_BUSDEC_WRITE_COUNT_EN
    ,
    .CC_BUSDEC_count_OutBUS  (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] load;
    logic [7:0]  data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_data = 0;   // data of the last accepted legal write
  int   strobes   = 0;   // legal writes accepted since reset
  bit   prev_pulse = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the response one accepted request should produce.
  task automatic push_expected(input int a, input int d);
    exp_t e;
    e.load = '0;
    e.err  = 1'b0;
    if (a < NR) begin
      if (a != 0) e.load[a] = 1'b1;
      last_data = d;
      strobes++;
    end else begin
      e.err = 1'b1;
    end
    e.data = 8'(last_data);
    sb.push_back(e);
  endtask

  // Present a request and hold it until the DUT accepts it; valid stays high afterwards.
  task automatic send(input int a, input int d);
    int n;
    @(negedge clk);
    valid = 1'b1;
    addr  = 4'(a);
    data  = 8'(d);
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("ready_timeout", {31'b0, ready}, 32'd1);
    end else begin
      push_expected(a, d);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
  endtask

  // Monitor: compare each done/error pulse against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pulse = 0;
    end else begin
      if (prev_pulse) check("ready_after_pulse", {31'b0, ready}, 32'd1);
      if (done || error) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'b0, done, error}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("load",       {20'b0, load},     {20'b0, mon_e.load});
          check("data_out",   {24'b0, data_out}, {24'b0, mon_e.data});
          check("done",       {31'b0, done},     {31'b0, !mon_e.err});
          check("error",      {31'b0, error},    {31'b0, mon_e.err});
          check("ready_busy", {31'b0, ready},    32'd0);
        end
        prev_pulse = 1;
      end else begin
        check("load_quiet", {20'b0, load}, 32'd0);
        prev_pulse = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    valid = 1'b0;
    addr  = '0;
    data  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready},    32'd1);
    check("rst_load",  {20'b0, load},     32'd0);
    check("rst_data",  {24'b0, data_out}, 32'd0);
    check("rst_done",  {31'b0, done},     32'd0);
    check("rst_error", {31'b0, error},    32'd0);
`ifdef CC_BUSDEC_WRITE_COUNT_EN
    check("rst_count", {24'b0, count},    32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases: legal, out of range, zero register, back-to-back with held valid.
    send(5, 8'hA7);
    idle(1);
    send(13, 8'h3C);
    idle(1);
    send(0, 8'hFF);
    idle(1);
    send(1, 8'h11);
    send(2, 8'h22);
    send(11, 8'h5B);
    send(12, 8'h66);
    send(15, 8'h77);
    idle(2);
    drain();

    // Reset in the middle of a STROBE aborts it without a clock edge.
    @(negedge clk);
    valid = 1'b1;
    addr  = 4'd11;
    data  = 8'h5A;
    @(posedge clk);
    #1 valid = 1'b0;
    #1 check("mid_strobe_load", {20'b0, load}, 32'h800);
    #1 rst_n = 1'b0;
    last_data = 0;
    strobes   = 0;
    #1;
    check("abort_load",  {20'b0, load},     32'd0);
    check("abort_done",  {31'b0, done},     32'd0);
    check("abort_ready", {31'b0, ready},    32'd1);
    check("abort_data",  {24'b0, data_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_ready", {31'b0, ready},    32'd1);
    check("post_abort_data",  {24'b0, data_out}, 32'd0);

    // Random traffic with valid held across STROBE/ERROR and occasional gaps.
    for (int i = 0; i < 200; i++) begin
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);
    drain();

`ifdef CC_BUSDEC_WRITE_COUNT_EN
    for (int i = 0; i < 300; i++) send(int'($urandom_range(0, 11)), int'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++)   send(int'($urandom_range(12, 15)), int'($urandom_range(0, 255)));
    idle(2);
    drain();
    @(negedge clk);
    check("count_saturated", {24'b0, count}, (strobes > 255) ? 32'd255 : 32'(strobes));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_bus_decoder_load.md
Name: cc_bus_decoder_load

Overview:
- Write-side counterpart of the bus source-select mux in the datapath. The mux chooses which register drives the bus; this block decodes the bus destination address into a one-hot register load strobe.
- It captures a write request (address + data) with a valid/ready handshake and validates the address.
- It emits a single-cycle one-hot load plus the held data for the register bank, then signals completion or error.
- It sits between the microsequencer / instruction-register address path and the register bank.

Parameters:
- DATAWIDTH_BUS, 4, destination address width.
- DATAWIDTH_DATA, 8, data word width.
- NUM_REGS, 12, number of loadable registers; legal addresses are 0..NUM_REGS-1.

Ports:
- CC_BUSDEC_CLOCK_50  in  1  system clock, rising edge.
- CC_BUSDEC_RESET_InLow  in  1  asynchronous active-low reset.
- CC_BUSDEC_valid_In  in  1  write request valid.
- CC_BUSDEC_address_InBUS  in  DATAWIDTH_BUS  destination register address.
- CC_BUSDEC_data_InBUS  in  DATAWIDTH_DATA  write data.
- CC_BUSDEC_ready_Out  out  1  block can accept a request.
- CC_BUSDEC_load_OutBUS  out  NUM_REGS  one-hot register load strobe.
- CC_BUSDEC_data_OutBUS  out  DATAWIDTH_DATA  captured data to the register bank.
- CC_BUSDEC_done_Out  out  1  one-cycle pulse: request completed (legal address).
- CC_BUSDEC_error_Out  out  1  one-cycle pulse: request rejected (address >= NUM_REGS).

Behaviour:
- One clock, CC_BUSDEC_CLOCK_50. Reset CC_BUSDEC_RESET_InLow is asynchronous, active-low.
- On reset assertion, immediately:
  - state=IDLE, ready=1;
  - load=0, data_OutBUS=0, done=0, error=0;
  - internal address/data registers cleared.
- FSM states: IDLE, STROBE, ERROR. All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - ready=1; load, done and error are 0.
  - A handshake occurs when valid=1 on a rising edge: address and data are captured.
  - If address < NUM_REGS, go to STROBE; otherwise go to ERROR.
  - If valid=0, remain in IDLE.
- STROBE (exactly 1 cycle):
  - ready=0; done=1; data_OutBUS holds the captured data.
  - load has bit[address]=1 and all other bits 0.
  - Exception: address 0 is the hardwired zero register, so load is all zero while done still pulses.
  - Next state is IDLE.
- ERROR (exactly 1 cycle):
  - ready=0; error=1; load=0; done=0.
  - data_OutBUS keeps its previous value.
  - Next state is IDLE.
- Latency and throughput:
  - Request accepted at edge N; load/done (or error) are high for the cycle following edge N; ready returns after edge N+1.
  - Maximum throughput is one request per 2 cycles.
- valid asserted while ready=0 is ignored: no capture, and the request is not queued. The requester must hold valid until it sees ready=1 at a sampling edge.
- data_OutBUS retains the last accepted legal write's data after STROBE. It updates only on acceptance of a legal address.
- Address width vs NUM_REGS: addresses are compared unsigned. With defaults, addresses 12..15 produce error.
- Reset asserted during STROBE or ERROR aborts immediately: the load strobe drops to 0 asynchronously and no done/error pulse completes.

Optional Feature:
- Macro CC_BUSDEC_WRITE_COUNT_EN.
- Defined:
  - Adds output port CC_BUSDEC_count_OutBUS (8 bits).
  - The counter increments by 1 on each cycle in STROBE, including address-0 writes.
  - It saturates at 255 and does not wrap.
  - It clears to 0 on reset; errors do not increment it.
- Not defined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, then valid=1, addr=5, data=0xA7 → next cycle load=12'h020, data_OutBUS=0xA7, done=1, ready=0; following cycle ready=1, load=0.
- valid=1, addr=13, data=0x3C → next cycle error=1, load=0, done=0, data_OutBUS unchanged; ready=1 one cycle later.
- valid=1, addr=0, data=0xFF → next cycle done=1, load=12'h000, data_OutBUS=0xFF.
- valid held high continuously with addr 1 then 2 (changed during STROBE) → strobes load=12'h002 then 12'h004 on alternating cycles; no capture during STROBE.
- Reset asserted mid-STROBE (addr=11) → load drops to 0 without a clock edge; after release state=IDLE, ready=1, data_OutBUS=0.
- With CC_BUSDEC_WRITE_COUNT_EN defined: 300 legal writes plus 3 illegal writes → count_OutBUS=255.
